// File: rtl/csla_pipe.sv
// Pipelined carry-select adder/subtractor with valid/ready handshake on both sides.
// Each stage resolves an equal slice of the select blocks and forwards its carry.
module csla_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;

  // a/b hold the effective operands, c the inter-block carry, m the carry into the MSB
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             m;
    logic             o;
  } beat_t;

  function automatic beat_t resolve(input beat_t d, input int k);
    beat_t          r;
    logic [BLOCK:0] sum0;
    logic [BLOCK:0] sum1;
    logic           sel;
    r = d;
    for (int j = 0; j < NBLK; j++) begin
      sel  = ((j / BPS) == k);
      sum0 = {1'b0, d.a[j*BLOCK +: BLOCK]} + {1'b0, d.b[j*BLOCK +: BLOCK]};
      sum1 = {1'b0, d.a[j*BLOCK +: BLOCK]} + {1'b0, d.b[j*BLOCK +: BLOCK]} + {{BLOCK{1'b0}}, 1'b1};
      r.s[j*BLOCK +: BLOCK] = sel ? (r.c ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0]) : r.s[j*BLOCK +: BLOCK];
      r.c = sel ? (r.c ? sum1[BLOCK] : sum0[BLOCK]) : r.c;
    end
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out of the resolved sum.
    r.m = (k == STAGES-1) ? (r.s[WIDTH-1] ^ d.a[WIDTH-1] ^ d.b[WIDTH-1]) : d.m;
    r.o = (k == STAGES-1) ? (r.m ^ r.c) : d.o;
    return r;
  endfunction

  beat_t in_s;
  beat_t nxt_s  [STAGES];
  beat_t stg_r  [STAGES];
  logic  vld_r  [STAGES];
  logic  load_s [STAGES];
  logic  move_s [STAGES];

  // Operand conditioning: subtract as a + ~b + ~cin.
  always_comb begin
    in_s.a = a;
    in_s.b = sub ? ~b : b;
    in_s.s = {WIDTH{1'b0}};
    in_s.c = sub ? ~cin : cin;
    in_s.m = 1'b0;
    in_s.o = 1'b0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    beat_t src_s;
    logic  src_v_s;

    if (k == 0) begin : g_head
      assign src_s   = in_s;
      assign src_v_s = in_valid;
    end else begin : g_body
      assign src_s   = stg_r[k-1];
      assign src_v_s = vld_r[k-1];
    end

    if (k == STAGES-1) begin : g_tail
      assign move_s[k] = vld_r[k] & out_ready;
    end else begin : g_mid
      assign move_s[k] = load_s[k+1];
    end

    // Empty stages always load, which lets bubbles collapse under a stalled output.
    assign load_s[k] = ~vld_r[k] | move_s[k];
    assign nxt_s[k]  = resolve(src_s, k);

    // Stage register: valid bit plus partially resolved beat.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_r[k] <= 1'b0;
        stg_r[k] <= '0;
      end else if (load_s[k]) begin
        vld_r[k] <= src_v_s;
        stg_r[k] <= nxt_s[k];
      end else begin
        vld_r[k] <= vld_r[k];
        stg_r[k] <= stg_r[k];
      end
    end
  end

  assign in_ready  = load_s[0];
  assign out_valid = vld_r[STAGES-1];
  assign s         = stg_r[STAGES-1].s;
  assign cout      = stg_r[STAGES-1].c;
  assign ovf       = stg_r[STAGES-1].o;

endmodule

// File: tb/tb_csla_pipe.sv
// Scoreboard bench for csla_pipe: a 32/4/2 instance for directed, back-pressure and
// reset cases, and a 64/8/4 instance for a random regression under random out_ready.
module tb_csla_pipe;

  typedef struct {
    logic [65:0] exp;
    int          cyc;
  } qent_t;

  logic        clk, rst;
  logic        a_in_valid, a_in_ready, a_cin, a_sub, a_out_valid, a_out_ready, a_cout, a_ovf;
  logic [31:0] a_a, a_b, a_s;
  logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready, w_cout, w_ovf;
  logic [63:0] w_a, w_b, w_s;

  int          n_pass, n_checks, cyc;
  qent_t       q_a[$];
  qent_t       q_w[$];
  bit          strict_v[2], hold_v[2], saw_stall[2], use_tab[2];
  logic [65:0] prev_v[2], tab_exp[2];
  string       pfx[2] = '{"a", "w"};
  int          lat[2] = '{2, 4};
  bit          w_done;

  logic        ov_s[2], or_s[2], iv_s[2], ir_s[2], cin_s[2], sub_s[2];
  logic [65:0] got_s[2];
  logic [63:0] opa_s[2], opb_s[2];

  assign ov_s[0]  = a_out_valid;  assign ov_s[1]  = w_out_valid;
  assign or_s[0]  = a_out_ready;  assign or_s[1]  = w_out_ready;
  assign iv_s[0]  = a_in_valid;   assign iv_s[1]  = w_in_valid;
  assign ir_s[0]  = a_in_ready;   assign ir_s[1]  = w_in_ready;
  assign cin_s[0] = a_cin;        assign cin_s[1] = w_cin;
  assign sub_s[0] = a_sub;        assign sub_s[1] = w_sub;
  assign opa_s[0] = {32'h0, a_a}; assign opa_s[1] = w_a;
  assign opb_s[0] = {32'h0, a_b}; assign opb_s[1] = w_b;
  assign got_s[0] = {a_cout, a_ovf, 32'h0, a_s};
  assign got_s[1] = {w_cout, w_ovf, w_s};

  csla_pipe #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .a(a_a), .b(a_b), .cin(a_cin), .sub(a_sub),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .s(a_s), .cout(a_cout), .ovf(a_ovf)
  );

  csla_pipe #(.WIDTH(64), .BLOCK(8), .STAGES(4)) dut_w (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .cin(w_cin), .sub(w_sub),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .s(w_s), .cout(w_cout), .ovf(w_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference from plain integer arithmetic: {cout, ovf, s} for a wd-bit operation.
  function automatic logic [65:0] model(input int wd, input logic [63:0] x, y, input logic c, sb);
    logic [64:0]        ua;
    logic [63:0]        mask, sv;
    logic               co, ov;
    logic signed [63:0] tx, ty;
    logic signed [65:0] sx, sy, sc, t, hi, lo;
    mask = (wd == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << wd) - 64'd1);
    if (sb) begin
      ua = {1'b0, x} - {1'b0, y} - {64'd0, c};
      co = ~ua[64];
    end else begin
      ua = {1'b0, x} + {1'b0, y} + {64'd0, c};
      co = ua[wd];
    end
    sv = ua[63:0] & mask;
    tx = $signed(x << (64 - wd)) >>> (64 - wd);
    ty = $signed(y << (64 - wd)) >>> (64 - wd);
    sx = tx;
    sy = ty;
    sc = $signed({65'd0, c});
    t  = sb ? (sx - sy - sc) : (sx + sy + sc);
    hi = (66'sd1 <<< (wd - 1)) - 66'sd1;
    lo = -hi - 66'sd1;
    ov = (t > hi) || (t < lo);
    return {co, ov, sv};
  endfunction

  task automatic mon(input int w);
    qent_t e;
    int    sz;
    if (hold_v[w]) begin
      check_eq({pfx[w], "_hold_valid"}, 66'(ov_s[w]), 66'd1);
      check_eq({pfx[w], "_hold_data"}, got_s[w], prev_v[w]);
    end
    hold_v[w] = ov_s[w] && !or_s[w];
    prev_v[w] = got_s[w];
    if (iv_s[w] && !ir_s[w]) saw_stall[w] = 1'b1;
    if (ov_s[w] && or_s[w]) begin
      if (w == 0) sz = q_a.size(); else sz = q_w.size();
      if (sz == 0) check_eq({pfx[w], "_spurious"}, 66'(ov_s[w]), 66'd0);
      else begin
        if (w == 0) e = q_a.pop_front(); else e = q_w.pop_front();
        check_eq({pfx[w], "_res"}, got_s[w], e.exp);
        if (strict_v[w]) check_eq({pfx[w], "_lat"}, 66'(cyc - e.cyc), 66'(lat[w]));
      end
    end
    if (iv_s[w] && ir_s[w]) begin
      e.cyc = cyc;
      e.exp = use_tab[w] ? tab_exp[w] : model((w == 0) ? 32 : 64, opa_s[w], opb_s[w], cin_s[w], sub_s[w]);
      if (w == 0) q_a.push_back(e); else q_w.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0);
      mon(1);
    end
  end

  task automatic send(input int w, input logic [63:0] x, y, input logic c, sb,
                      input bit tab, input logic [65:0] e);
    bit done;
    done       = 1'b0;
    use_tab[w] = tab;
    tab_exp[w] = e;
    if (w == 0) begin
      a_a = x[31:0]; a_b = y[31:0]; a_cin = c; a_sub = sb; a_in_valid = 1'b1;
    end else begin
      w_a = x; w_b = y; w_cin = c; w_sub = sb; w_in_valid = 1'b1;
    end
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = ir_s[w];
      @(posedge clk);
      #1;
    end
    if (!done) check_eq({pfx[w], "_send_timeout"}, 66'(ir_s[w]), 66'd1);
  endtask

  task automatic idle(input int w);
    if (w == 0) a_in_valid = 1'b0; else w_in_valid = 1'b0;
  endtask

  task automatic drain(input int w);
    int sz;
    for (int i = 0; i < 400; i++) begin
      if (w == 0) sz = q_a.size(); else sz = q_w.size();
      if (sz != 0) begin @(posedge clk); #1; end
    end
    if (w == 0) sz = q_a.size(); else sz = q_w.size();
    check_eq({pfx[w], "_drain"}, 66'(sz), 66'd0);
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'hFFFF_FFFF_FFFF_FFFF;
      1:       return 64'h0;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  logic [31:0] t_a[6]  = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'h8000_0000, 32'd10};
  logic [31:0] t_b[6]  = '{32'h0, 32'h1, 32'h8000_0000, 32'd7, 32'h1, 32'd3};
  logic        t_c[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        t_sb[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] t_s[6]  = '{32'h0, 32'h8000_0000, 32'h0, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h6};
  logic        t_co[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic        t_ov[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cyc = 0; n_pass = 0; n_checks = 0; w_done = 1'b0;
    a_in_valid = 1'b0; a_a = '0; a_b = '0; a_cin = 1'b0; a_sub = 1'b0; a_out_ready = 1'b1;
    w_in_valid = 1'b0; w_a = '0; w_b = '0; w_cin = 1'b0; w_sub = 1'b0; w_out_ready = 1'b1;
    strict_v = '{1'b1, 1'b0};
    #12;
    check_eq("a_rst_out_valid", 66'(a_out_valid), 66'd0);
    check_eq("a_rst_result", got_s[0], 66'd0);
    check_eq("a_rst_in_ready", 66'(a_in_ready), 66'd1);
    check_eq("w_rst_out_valid", 66'(w_out_valid), 66'd0);
    check_eq("w_rst_in_ready", 66'(w_in_ready), 66'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Directed arithmetic corners, unstalled, back to back.
    for (int i = 0; i < 6; i++)
      send(0, {32'h0, t_a[i]}, {32'h0, t_b[i]}, t_c[i], t_sb[i], 1'b1, {t_co[i], t_ov[i], 32'h0, t_s[i]});
    idle(0);
    drain(0);

    // Back-pressure: out_ready low for cycles 3-6 of a 6-beat stream.
    strict_v[0]  = 1'b0;
    saw_stall[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(0, {32'h0, $urandom}, {32'h0, $urandom}, 1'($urandom_range(0, 1)),
                                         1'($urandom_range(0, 1)), 1'b0, 66'd0);
        idle(0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 a_out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 a_out_ready = 1'b1;
      end
    join
    drain(0);
    check_eq("a_in_ready_drop", 66'(saw_stall[0]), 66'd1);

    // Free-running stream: one result per cycle at fixed latency.
    strict_v[0]  = 1'b1;
    saw_stall[0] = 1'b0;
    for (int i = 0; i < 6; i++) send(0, {32'h0, $urandom}, {32'h0, $urandom}, 1'($urandom_range(0, 1)),
                                     1'($urandom_range(0, 1)), 1'b0, 66'd0);
    idle(0);
    drain(0);
    check_eq("a_no_stall", 66'(saw_stall[0]), 66'd0);

    // Reset between edges with two beats in flight.
    send(0, 64'd100, 64'd200, 1'b0, 1'b0, 1'b0, 66'd0);
    send(0, 64'd300, 64'd400, 1'b0, 1'b1, 1'b0, 66'd0);
    idle(0);
    check_eq("a_pre_rst_valid", 66'(a_out_valid), 66'd1);
    #3 rst = 1'b1;
    #1;
    check_eq("a_async_rst_valid", 66'(a_out_valid), 66'd0);
    q_a.delete();
    hold_v = '{1'b0, 1'b0};
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("a_no_stale", 66'(a_out_valid), 66'd0);
    end
    @(posedge clk); #1;
    send(0, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0, 32'h2345_6789});
    idle(0);
    drain(0);

    // Wide random regression with random back-pressure.
    fork
      begin
        while (!w_done) begin
          @(posedge clk);
          #1 w_out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) begin idle(1); @(posedge clk); #1; end
          send(1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 66'd0);
        end
        idle(1);
        w_done = 1'b1;
      end
    join
    w_out_ready = 1'b1;
    drain(1);
    strict_v[1] = 1'b1;
    for (int i = 0; i < 40; i++)
      send(1, rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 66'd0);
    idle(1);
    drain(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csla_pipe.md
Name: csla_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor; next generation of the team's fixed 32-bit, 4-bit-block carry-select adder.
- Operand width, select-block size and pipeline depth are parameters.
- Adds subtract mode, signed overflow and a valid/ready handshake on both sides.
- Sits between operand registers and the datapath result bus. Sustains one operation per clock when the output is not back-pressured.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of BLOCK.
BLOCK, 4, carry-select block width in bits.
STAGES, 2, register stages; NBLK = WIDTH/BLOCK must be divisible by STAGES; STAGES >= 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block accepts beat this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in (add) / borrow-in (sub)
sub  in  1  0 = A+B+cin; 1 = A-B-cin
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
s  out  WIDTH  sum/difference
cout  out  1  carry-out (add) / NOT borrow-out (sub)
ovf  out  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high; it clears all stage valid bits immediately.
- Reset values: out_valid=0, s=0, cout=0, ovf=0. in_ready reads 1 while every stage is empty.
- Transfer rules: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Arithmetic:
  - Effective B = sub ? ~b : b. Effective carry-in = sub ? ~cin : cin.
  - Hence sub=1 gives a + ~b + ~cin = a - b - cin.
  - Each BLOCK-bit block computes sum0/carry0 (carry-in 0) and sum1/carry1 (carry-in 1) in parallel. The incoming block carry muxes the pair, as in a classic CSLA.
  - Block 0 uses the effective carry-in directly.
- Pipelining:
  - Stage k (0..STAGES-1) resolves blocks k*NBLK/STAGES .. (k+1)*NBLK/STAGES-1.
  - The stage register carries: resolved low sum bits, the inter-block carry, unprocessed effective operand bits, and the carry into the MSB once resolved.
- Outputs:
  - cout = carry out of the MSB.
  - ovf = carry into the MSB XOR carry out of the MSB. This is valid in both modes.
- Latency: exactly STAGES cycles from the input transfer to out_valid, with out_ready held 1.
- Per-stage handshake:
  - Stage k loads when it is empty or its contents move on this cycle.
  - Stage STAGES-1 moves on an output transfer; stage k<STAGES-1 moves when stage k+1 loads.
  - in_ready = stage 0 loads.
  - Bubbles collapse: an empty downstream stage is filled even while the output is stalled.
- Stall: while out_valid=1 and out_ready=0, s/cout/ovf/out_valid are held bit-stable. Upstream stages fill, then in_ready drops to 0.
- Full and simultaneous:
  - With every stage full, an output transfer and an input transfer may happen in the same cycle.
  - Throughput is 1 per cycle; no beat is dropped or duplicated.
- in_valid=0: no stage loads new data; the contents of empty stages do not matter, but their valid bits stay 0.
- Reset mid-operation: all in-flight beats are discarded. out_valid drops asynchronously on rst assertion. The first beat after deassertion behaves as from power-up.
- Width rules: no internal truncation. Result bits above WIDTH do not exist; cout is the only carry observable beyond WIDTH.

Test Plan:
- WIDTH=32, BLOCK=4, STAGES=2, out_ready=1. Apply a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 -> after 2 cycles s=0x00000000, cout=1, ovf=0. The carry ripples through all 8 blocks across both stages.
- a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> s=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000 -> s=0x00000000, cout=1, ovf=1.
- sub=1:
  - a=5, b=7, cin=0 -> s=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, cin=0 -> s=0x7FFFFFFF, cout=1, ovf=1.
  - a=10, b=3, cin=1 -> s=0x00000006, cout=1.
- Back-pressure:
  - Stream 6 back-to-back beats with out_ready low for cycles 3-6. Required: in_ready falls once both stages are full, outputs are held stable, and all 6 results appear in order with no loss.
  - Then out_ready=1 continuously -> 1 result per cycle.
- Reset mid-operation: assert rst asynchronously (between edges) with 2 beats in flight. Required: out_valid=0 immediately; after release, no stale result appears; the next beat returns its correct result after 2 cycles.
- Random regression with WIDTH=64, BLOCK=8, STAGES=4 and random out_ready: every result equals the reference {cout,s} = a ± b ± cin and the signed-overflow model, in order, with latency 4 when unstalled.
